// File: rtl/input_process_spi_if.sv
// Bundle of the serial link pins and the parallel consumer side of the SPI receive block.
interface input_process_spi_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          RX_DATA;
  logic          RX_LOAD;
  logic          TX_STOP;
  logic [15:0]   DATA;
  logic          VALID;
  logic          RD;
  logic [LW-1:0] LEVEL;
  logic          FRAME_ERR;
  logic          OVERFLOW;

  modport slave (
    input  RX_DATA, RX_LOAD, RD,
    output TX_STOP, DATA, VALID, LEVEL, FRAME_ERR, OVERFLOW
  );

  modport master (
    output RX_DATA, RX_LOAD, RD,
    input  TX_STOP, DATA, VALID, LEVEL, FRAME_ERR, OVERFLOW
  );
endinterface

// File: rtl/input_process_spi.sv
// SPI-style link receiver: deserializes start+addr+data frames, filters on address,
// buffers accepted words in a show-ahead FIFO and raises TX_STOP as flow control.
module input_process_spi #(
  parameter logic [2:0] ADDR        = 3'h1,
  parameter int         DEPTH       = 16,
  parameter int         STOP_MARGIN = 4
) (
  input  logic RX_CLK,
  input  logic RST,
  input_process_spi_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] STOP_LVL = LW'(DEPTH - STOP_MARGIN);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [18:0]   sr_q, sr_d;
  logic          frame_err_q, frame_err_d;
  logic          wr_pend_q, wr_pend_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          tx_stop_q, tx_stop_d;
  logic          overflow_q, overflow_d;
  logic          pop_s, push_ok_s;
  logic [18:0]   frame_s;

  always_ff @(posedge RX_CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.RX_LOAD) state_d = IDLE;
        else if (bus.RX_DATA) state_d = SHIFT;
        else state_d = IDLE;
      end
      SHIFT: begin
        if (bus.RX_LOAD || (cnt_q == 5'd18)) state_d = IDLE;
        else state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  // The completed frame includes the bit sampled together with RX_LOAD.
  always_comb begin
    frame_s     = {sr_q[17:0], bus.RX_DATA};
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    frame_err_d = 1'b0;
    wr_pend_d   = 1'b0;
    wr_data_d   = wr_data_q;
    case (state_q)
      IDLE: begin
        cnt_d = 5'd0;
        if (bus.RX_LOAD) frame_err_d = 1'b1;
        else frame_err_d = 1'b0;
      end
      SHIFT: begin
        sr_d  = frame_s;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd18) begin
          if (!bus.RX_LOAD) begin
            frame_err_d = 1'b1;
          end else if (frame_s[18:16] == ADDR) begin
            wr_pend_d = 1'b1;
            wr_data_d = frame_s[15:0];
          end else begin
            wr_pend_d = 1'b0;
          end
        end else if (bus.RX_LOAD) begin
          frame_err_d = 1'b1;
        end else begin
          frame_err_d = 1'b0;
        end
      end
      default: begin
        cnt_d = 5'd0;
      end
    endcase
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a word alongside RD.
  always_comb begin
    pop_s      = bus.RD && valid_q;
    push_ok_s  = wr_pend_q && ((level_q != FULL_LVL) || pop_s);
    overflow_d = wr_pend_q && !push_ok_s;
    wr_ptr_d   = push_ok_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    level_d    = level_q + LW'(push_ok_s) - LW'(pop_s);
    valid_d    = (level_d != {LW{1'b0}});
    tx_stop_d  = (level_d >= STOP_LVL);
    if (level_d == {LW{1'b0}}) begin
      data_d = 16'h0000;
    end else if (push_ok_s && (rd_ptr_d == wr_ptr_q)) begin
      data_d = wr_data_q;
    end else begin
      data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data_q;
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (RST) begin
      cnt_q       <= 5'd0;
      sr_q        <= 19'd0;
      frame_err_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_data_q   <= 16'h0000;
      rd_ptr_q    <= {PW{1'b0}};
      wr_ptr_q    <= {PW{1'b0}};
      level_q     <= {LW{1'b0}};
      data_q      <= 16'h0000;
      valid_q     <= 1'b0;
      tx_stop_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      frame_err_q <= frame_err_d;
      wr_pend_q   <= wr_pend_d;
      wr_data_q   <= wr_data_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      tx_stop_q   <= tx_stop_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.TX_STOP   = tx_stop_q;
  assign bus.DATA      = data_q;
  assign bus.VALID     = valid_q;
  assign bus.LEVEL     = level_q;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.OVERFLOW  = overflow_q;
endmodule

// File: tb/tb_input_process_spi.sv
// Directed bench for input_process_spi: framing, address filter, FIFO fill/overflow,
// flow control, malformed frames and mid-frame reset.
module tb_input_process_spi;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   ferr_cnt;
  int   ovf_cnt;
  logic seen12;
  logic stop_at12;
  logic seen11;
  logic stop_at11;

  input_process_spi_if #(.DEPTH(16)) bus ();

  input_process_spi #(.ADDR(3'h1), .DEPTH(16), .STOP_MARGIN(4)) dut (
    .RX_CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    ferr_cnt  = 0;
    ovf_cnt   = 0;
    seen12    = 1'b0;
    stop_at12 = 1'b0;
    seen11    = 1'b0;
    stop_at11 = 1'b1;
  end

  // Pulse counters and the first-sample record of TX_STOP at levels 11 and 12.
  always @(negedge clk) begin
    if (bus.FRAME_ERR === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (bus.OVERFLOW === 1'b1) ovf_cnt <= ovf_cnt + 1;
    if (!rst && bus.LEVEL == 5'd12 && !seen12) begin
      seen12    <= 1'b1;
      stop_at12 <= bus.TX_STOP;
    end
    if (!rst && bus.LEVEL == 5'd11 && !seen11) begin
      seen11    <= 1'b1;
      stop_at11 <= bus.TX_STOP;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.RX_DATA = 1'b0;
    bus.RX_LOAD = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Sends the first nbits of a frame; RX_LOAD goes high on bit number load_at (1-based, 0 = never).
  task automatic send_frame(input logic [2:0] a, input logic [15:0] d, input int load_at, input int nbits);
    logic [19:0] fr;
    fr = {1'b1, a, d};
    for (int i = 0; i < nbits; i++) begin
      bus.RX_DATA = fr[19-i];
      bus.RX_LOAD = ((i + 1) == load_at);
      tick();
    end
    bus.RX_DATA = 1'b0;
    bus.RX_LOAD = 1'b0;
  endtask

  task automatic pop();
    bus.RD = 1'b1;
    tick();
    bus.RD = 1'b0;
  endtask

  initial begin
    int f0;
    int o0;
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.RX_DATA = 1'b0;
    bus.RX_LOAD = 1'b0;
    bus.RD      = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", 32'(bus.VALID), 32'd0);
    check_eq("rst_level", 32'(bus.LEVEL), 32'd0);
    check_eq("rst_data", 32'(bus.DATA), 32'h0);
    check_eq("rst_txstop", 32'(bus.TX_STOP), 32'd0);
    check_eq("rst_ferr", 32'(bus.FRAME_ERR), 32'd0);
    check_eq("rst_ovf", 32'(bus.OVERFLOW), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single frame, latency and pop
    send_frame(3'h1, 16'hA5C3, 20, 20);
    check_eq("lat_valid_early", 32'(bus.VALID), 32'd0);
    idle(1);
    check_eq("t1_valid", 32'(bus.VALID), 32'd1);
    check_eq("t1_data", 32'(bus.DATA), 32'hA5C3);
    check_eq("t1_level", 32'(bus.LEVEL), 32'd1);
    pop();
    check_eq("t1_valid_pop", 32'(bus.VALID), 32'd0);
    check_eq("t1_level_pop", 32'(bus.LEVEL), 32'd0);

    // Foreign address is dropped silently
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    send_frame(3'h2, 16'h1234, 20, 20);
    idle(2);
    check_eq("t2_level", 32'(bus.LEVEL), 32'd0);
    check_eq("t2_ferr", 32'(ferr_cnt - f0), 32'd0);
    check_eq("t2_ovf", 32'(ovf_cnt - o0), 32'd0);

    // 13 back-to-back frames, TX_STOP threshold
    for (int k = 0; k < 13; k++) begin
      send_frame(3'h1, 16'(k), 20, 20);
      check_eq("t3_level_fill", 32'(bus.LEVEL), 32'(k));
    end
    idle(1);
    check_eq("t3_level13", 32'(bus.LEVEL), 32'd13);
    check_eq("t3_txstop13", 32'(bus.TX_STOP), 32'd1);
    check_eq("t3_seen12", 32'(seen12), 32'd1);
    check_eq("t3_stop_at12", 32'(stop_at12), 32'd1);
    check_eq("t3_stop_at11", 32'(stop_at11), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_eq("t3_data_seq", 32'(bus.DATA), 32'(k));
      pop();
    end
    check_eq("t3_level9", 32'(bus.LEVEL), 32'd9);
    check_eq("t3_txstop9", 32'(bus.TX_STOP), 32'd0);
    for (int k = 4; k < 13; k++) begin
      check_eq("t3_data_drain", 32'(bus.DATA), 32'(k));
      pop();
    end
    check_eq("t3_empty", 32'(bus.VALID), 32'd0);

    // Fill to DEPTH, overflow, then write alongside a pop
    for (int k = 0; k < 16; k++) send_frame(3'h1, 16'h0100 + 16'(k), 20, 20);
    idle(1);
    check_eq("t4_full", 32'(bus.LEVEL), 32'd16);
    check_eq("t4_txstop", 32'(bus.TX_STOP), 32'd1);
    o0 = ovf_cnt;
    send_frame(3'h1, 16'hDEAD, 20, 20);
    idle(2);
    check_eq("t4_ovf_pulse", 32'(ovf_cnt - o0), 32'd1);
    check_eq("t4_level_ovf", 32'(bus.LEVEL), 32'd16);
    check_eq("t4_head_kept", 32'(bus.DATA), 32'h0100);
    send_frame(3'h1, 16'hDEAD, 20, 20);
    pop();
    idle(1);
    check_eq("t4_no_ovf", 32'(ovf_cnt - o0), 32'd1);
    check_eq("t4_level_rw", 32'(bus.LEVEL), 32'd16);
    for (int k = 0; k < 16; k++) begin
      check_eq("t4_drain", 32'(bus.DATA), (k < 15) ? (32'h0101 + 32'(k)) : 32'hDEAD);
      pop();
    end
    check_eq("t4_empty", 32'(bus.LEVEL), 32'd0);

    // Malformed frames
    f0 = ferr_cnt;
    send_frame(3'h1, 16'h1111, 10, 10);
    idle(2);
    check_eq("t5_early_ferr", 32'(ferr_cnt - f0), 32'd1);
    check_eq("t5_early_level", 32'(bus.LEVEL), 32'd0);
    send_frame(3'h1, 16'h5A5A, 20, 20);
    idle(1);
    check_eq("t5_good_data", 32'(bus.DATA), 32'h5A5A);
    check_eq("t5_good_level", 32'(bus.LEVEL), 32'd1);
    pop();
    f0 = ferr_cnt;
    send_frame(3'h1, 16'h2222, 0, 20);
    idle(2);
    check_eq("t5_noload_ferr", 32'(ferr_cnt - f0), 32'd1);
    check_eq("t5_noload_level", 32'(bus.LEVEL), 32'd0);

    // Reset mid-frame with words buffered
    for (int k = 1; k < 4; k++) send_frame(3'h1, 16'h0300 + 16'(k), 20, 20);
    idle(1);
    check_eq("t6_level3", 32'(bus.LEVEL), 32'd3);
    f0 = ferr_cnt;
    send_frame(3'h1, 16'h7777, 20, 8);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_level", 32'(bus.LEVEL), 32'd0);
    check_eq("t6_rst_valid", 32'(bus.VALID), 32'd0);
    check_eq("t6_rst_txstop", 32'(bus.TX_STOP), 32'd0);
    check_eq("t6_rst_data", 32'(bus.DATA), 32'h0);
    rst = 1'b0;
    idle(3);
    check_eq("t6_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    send_frame(3'h1, 16'hBEEF, 20, 20);
    idle(1);
    check_eq("t6_beef", 32'(bus.DATA), 32'hBEEF);
    check_eq("t6_level1", 32'(bus.LEVEL), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/input_process_spi.md
Name: input_process_spi

Overview:
- Receive end of the serial SPI-style link driven by the output SPI path.
- Detects frames on RX_DATA/RX_LOAD, deserializes them into 3-bit address + 16-bit data words, and filters on address.
- Buffers accepted words in an internal show-ahead FIFO and drives TX_STOP back to the transmitter (its RX_STOP) as flow control.
- Sits between the board's link pins and the parallel consumer logic.

Parameters:
- ADDR, 3'h1, link address accepted by this instance; frames with any other address are discarded silently.
- DEPTH, 16, FIFO depth in words; power of two, minimum 4.
- STOP_MARGIN, 4, free-slot threshold for asserting TX_STOP; 1 to DEPTH-1.

Ports:
- RX_CLK  in  1  link/system clock; the single clock of the block.
- RST  in  1  synchronous, active-high reset.
- RX_DATA  in  1  serial data, MSB first, sampled on rising RX_CLK.
- RX_LOAD  in  1  high together with the last bit of a frame.
- TX_STOP  out  1  backpressure to the transmitter (its RX_STOP); registered.
- DATA  out  16  head-of-FIFO word; show-ahead.
- VALID  out  1  FIFO not empty; DATA is meaningful.
- RD  in  1  pops the head word when VALID=1; ignored when VALID=0.
- LEVEL  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- FRAME_ERR  out  1  one-cycle pulse on a malformed frame.
- OVERFLOW  out  1  one-cycle pulse when an accepted word is dropped because the FIFO is full.

Behaviour:
- Frame format: start bit '1', then 3 address bits, then 16 data bits, MSB first; 20 bits total. Line idles low. RX_LOAD=1 only on the 20th bit. No idle gap between frames is required.
- Receive FSM, two states, IDLE and SHIFT:
  - IDLE: RX_DATA=1 -> SHIFT, bit counter cleared.
  - IDLE: RX_LOAD=1 -> FRAME_ERR pulse, stay in IDLE.
  - SHIFT: shift RX_DATA into a 19-bit register and increment the counter every cycle.
  - SHIFT, 19th shifted bit (counter = 18) with RX_LOAD=1 -> frame complete, go to IDLE.
  - SHIFT, RX_LOAD=1 before counter = 18 -> FRAME_ERR, frame discarded, go to IDLE.
  - SHIFT, counter = 18 with RX_LOAD=0 -> FRAME_ERR, frame discarded, go to IDLE.
- Frame complete: if address field == ADDR, the 16-bit data field is registered as a write request on the next cycle. Otherwise the frame is dropped with no flag.
- Latency: last bit (RX_LOAD=1) sampled at edge N; word written to the FIFO at edge N+1; VALID/DATA/LEVEL updated after edge N+1 (visible in cycle N+1, for an empty FIFO).
- FIFO:
  - Write accepted if LEVEL < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and OVERFLOW pulses for 1 cycle; FIFO contents are unaffected.
  - Simultaneous write and pop: LEVEL unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - Pop: RD=1 and VALID=1 advances the head; DATA shows the next word in the following cycle.
- TX_STOP: registered; 1 when LEVEL >= DEPTH-STOP_MARGIN, evaluated on the post-update level; 0 otherwise. No hysteresis.
- Reset (RST=1 at a rising edge):
  - State IDLE; counter, shift register and pending write cleared; FIFO emptied.
  - Outputs: TX_STOP=0, VALID=0, DATA=0, LEVEL=0, FRAME_ERR=0, OVERFLOW=0.
  - A partial frame in progress is discarded without FRAME_ERR. The receiver resynchronizes on the next start bit after RST deasserts.
- RX_DATA content in IDLE other than a start bit is ignored.

Test Plan:
- Frame 1,001,16'hA5C3 with RX_LOAD on bit 20 -> VALID=1 and DATA=16'hA5C3 one cycle after the RX_LOAD edge; LEVEL=1; RD pulse -> VALID=0, LEVEL=0.
- Frame with address 3'h2 carrying 16'h1234 -> no write, LEVEL stays 0, FRAME_ERR=0, OVERFLOW=0.
- Back-to-back 13 frames 16'h0000..16'h000C, no RD (DEPTH=16, STOP_MARGIN=4) -> TX_STOP rises the cycle LEVEL reaches 12, stays high; 4 RD pops -> LEVEL=9, TX_STOP=0; DATA sequence in order starting 16'h0000.
- Fill to 16, send 16'hDEAD -> OVERFLOW pulses 1 cycle, LEVEL=16; repeat with RD asserted in the write cycle -> accepted, LEVEL=16, no OVERFLOW, 16'hDEAD read last.
- RX_LOAD on bit 10 of a frame -> FRAME_ERR 1 cycle, no write; following well-formed frame 16'h5A5A is received correctly. Frame of 20 bits without RX_LOAD -> FRAME_ERR.
- RST asserted mid-frame (bit 8) with LEVEL=3 -> next cycle LEVEL=0, VALID=0, TX_STOP=0, no FRAME_ERR; next full frame 16'hBEEF received.
